// File: rtl/kong_game_ctrl.sv
// Kong game-flow sequencer: spawn/play/death/level-up/game-over phases,
// lives and level tracking, and per-frame gating of the kong motion logic.
module kong_game_ctrl #(
    parameter int INIT_LIVES      = 3,
    parameter int SPAWN_FRAMES    = 30,
    parameter int DIE_FRAMES      = 60,
    parameter int LEVEL_FRAMES    = 90,
    parameter int GAMEOVER_FRAMES = 120,
    parameter int FALL_LIMIT      = 470,
    parameter int MAX_LEVEL       = 9
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        key_start,
    input  logic        collision_hazard,
    input  logic        collision_goal,
    input  logic [10:0] kong_topY,
    output logic        kong_sof,
    output logic        kong_resetN,
    output logic        keys_enable,
    output logic [2:0]  game_state,
    output logic [2:0]  lives,
    output logic [3:0]  level
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_PLAY  = 3'd2,
        S_DYING = 3'd3,
        S_LEVEL = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam logic [7:0]         T_SPAWN = 8'(SPAWN_FRAMES - 1);
    localparam logic [7:0]         T_DIE   = 8'(DIE_FRAMES - 1);
    localparam logic [7:0]         T_LEVEL = 8'(LEVEL_FRAMES - 1);
    localparam logic [7:0]         T_OVER  = 8'(GAMEOVER_FRAMES - 1);
    localparam logic [2:0]         L_INIT  = 3'(INIT_LIVES);
    localparam logic [3:0]         L_MAX   = 4'(MAX_LEVEL);
    localparam logic signed [10:0] FALL_Y  = 11'(FALL_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] lives_q, lives_d;
    logic [3:0] level_q, level_d;
    logic       hit_hazard, hit_goal, start_req, key_d;
    logic       expired, fallen;

    // key_d resets high so a key already held at reset gives no edge
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_hazard <= 1'b0;
            hit_goal   <= 1'b0;
            start_req  <= 1'b0;
            key_d      <= 1'b1;
        end else begin
            key_d <= key_start;
            if (startOfFrame) begin
                hit_hazard <= 1'b0;
                hit_goal   <= 1'b0;
                start_req  <= 1'b0;
            end else begin
                hit_hazard <= hit_hazard | collision_hazard;
                hit_goal   <= hit_goal | collision_goal;
                start_req  <= start_req | (key_start & ~key_d);
            end
        end
    end

    assign expired = (timer_q == 8'd0);
    assign fallen  = ($signed(kong_topY) >= FALL_Y);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        lives_d = lives_q;
        level_d = level_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d = S_SPAWN;
                    timer_d = T_SPAWN;
                    lives_d = L_INIT;
                    level_d = 4'd1;
                end
            end
            S_SPAWN: begin
                if (expired) state_d = S_PLAY;
                else         timer_d = timer_q - 8'd1;
            end
            S_PLAY: begin
                if (hit_hazard || fallen) begin
                    state_d = S_DYING;
                    timer_d = T_DIE;
                end else if (hit_goal) begin
                    state_d = S_LEVEL;
                    timer_d = T_LEVEL;
                end
            end
            S_DYING: begin
                if (!expired) begin
                    timer_d = timer_q - 8'd1;
                end else if (lives_q <= 3'd1) begin
                    state_d = S_OVER;
                    timer_d = T_OVER;
                    lives_d = 3'd0;
                end else begin
                    state_d = S_SPAWN;
                    timer_d = T_SPAWN;
                    lives_d = lives_q - 3'd1;
                end
            end
            S_LEVEL: begin
                if (!expired) begin
                    timer_d = timer_q - 8'd1;
                end else begin
                    state_d = S_SPAWN;
                    timer_d = T_SPAWN;
                    level_d = (level_q >= L_MAX) ? L_MAX : level_q + 4'd1;
                end
            end
            S_OVER: begin
                if (expired) state_d = S_IDLE;
                else         timer_d = timer_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            timer_q     <= 8'd0;
            lives_q     <= L_INIT;
            level_q     <= 4'd1;
            kong_resetN <= 1'b0;
            keys_enable <= 1'b0;
        end else if (startOfFrame) begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            kong_resetN <= (state_d == S_PLAY) || (state_d == S_DYING) ||
                           (state_d == S_LEVEL);
            keys_enable <= (state_d == S_PLAY);
        end
    end

    assign kong_sof   = startOfFrame & (state_q == S_PLAY);
    assign game_state = state_q;
    assign lives      = lives_q;
    assign level      = level_q;

endmodule

// File: doc/kong_game_ctrl.md
Name: kong_game_ctrl

Overview:
Game-flow sequencer for the Kong player datapath. It owns the per-frame run/freeze of the kong motion logic by gating its startOfFrame strobe and driving its reset. It decides spawn, play, death, level-up and game-over phases from latched per-frame events. It tracks lives and level and exposes them to the HUD.

Parameters:
INIT_LIVES, 3, lives loaded on game start (1..7)
SPAWN_FRAMES, 30, frames kong is held in reset before play
DIE_FRAMES, 60, frames of frozen death sequence
LEVEL_FRAMES, 90, frames of frozen level-complete sequence
GAMEOVER_FRAMES, 120, frames in GAME_OVER before returning to IDLE
FALL_LIMIT, 470, signed Y (pixels) at or beyond which kong counts as fallen
MAX_LEVEL, 9, level counter saturation value

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clk strobe per video frame
key_start  in  1  start key, level
collision_hazard  in  1  kong pixel overlaps enemy/barrel pixel (per-pixel strobe)
collision_goal  in  1  kong pixel overlaps goal object (per-pixel strobe)
kong_topY  in  11  kong top-left Y, two's complement
kong_sof  out  1  gated frame strobe to kong motion logic
kong_resetN  out  1  active-low reset to kong motion logic
keys_enable  out  1  1 = keypad routed to kong
game_state  out  3  0 IDLE, 1 SPAWN, 2 PLAY, 3 DYING, 4 LEVEL_UP, 5 GAME_OVER
lives  out  3  remaining lives
level  out  4  current level, starts at 1

Behaviour:
- Reset is clk and resetN, asynchronous active-low. Reset values: state IDLE, lives=INIT_LIVES, level=1, timer=0, all latches 0, kong_resetN=0, keys_enable=0. kong_sof is 0 because state is not PLAY.
- In-frame latches are sticky ORs, updated every clk:
  - hit_hazard |= collision_hazard.
  - hit_goal |= collision_goal.
  - start_req |= rising edge of key_start. Keep a 1-clk delayed copy; a key held through reset does not count.
  - All latches clear on the startOfFrame clk; input on that clk is dropped.
  - The latch values sampled on the startOfFrame clk are the frame's events.
- State and counter updates happen only on startOfFrame clks. Between strobes all registers hold.
- Timer protocol:
  - On entry to a timed state, timer = N-1.
  - On each startOfFrame: if timer==0, take the exit transition; else timer decrements.
  - The state therefore lasts exactly N frames. A value of N=1 lasts one frame.
- IDLE: if start_req, go to SPAWN with lives=INIT_LIVES, level=1, timer=SPAWN_FRAMES-1.
- SPAWN: on timer expiry, go to PLAY.
- PLAY: checks run on each startOfFrame, in this priority order:
  1. hit_hazard, or signed(kong_topY) >= FALL_LIMIT: go to DYING, timer=DIE_FRAMES-1.
  2. Else hit_goal: go to LEVEL_UP, timer=LEVEL_FRAMES-1.
  3. Else stay in PLAY.
  - Hazard and goal in the same frame resolve to DYING.
- DYING: on expiry, if lives==1 then lives=0 and go to GAME_OVER with timer=GAMEOVER_FRAMES-1. Otherwise lives-=1 and go to SPAWN with timer=SPAWN_FRAMES-1.
- LEVEL_UP: on expiry, level = min(level+1, MAX_LEVEL), lives unchanged, go to SPAWN with timer=SPAWN_FRAMES-1.
- GAME_OVER: on expiry go to IDLE. lives and level hold their final values until the next start. A start_req during GAME_OVER is discarded.
- Events latched outside PLAY are ignored.
- Outputs:
  - kong_sof = startOfFrame & (registered state==PLAY), combinational. The frame that causes PLAY→DYING still delivers kong_sof. The first kong_sof arrives on the frame after SPAWN exits.
  - kong_resetN and keys_enable are registered and updated on startOfFrame from the next state.
  - kong_resetN=1 in PLAY, DYING and LEVEL_UP; 0 otherwise. Kong is frozen, not reset, during DYING and LEVEL_UP.
  - keys_enable=1 only in PLAY.
- Arithmetic: timer is 8 bits unsigned; all *_FRAMES parameters are ≤256. lives is 3 bits and never underflows. level is 4 bits and saturates.
- resetN asserted mid-sequence returns everything to reset values immediately.

Test Plan:
- Reset, then key_start pulse in frame 2 → SPAWN on the 3rd SOF. kong_resetN=0 for 30 frames, then PLAY with kong_resetN=1 and keys_enable=1. The first kong_sof comes one frame later. lives=3, level=1.
- In PLAY, one collision_hazard pixel strobe in a frame → DYING at that SOF. kong_sof=0 for 60 frames, then SPAWN with lives=2.
- kong_topY=11'd470 at SOF → DYING. kong_topY=11'h7F0 (−16) → stays in PLAY.
- Hazard and goal in the same frame → DYING, and level is unchanged. Goal alone → LEVEL_UP for 90 frames, then level=2 and lives unchanged. From level 9, goal → level stays 9.
- Three deaths from INIT_LIVES=3 → GAME_OVER with lives=0. key_start pulses are ignored. After 120 frames → IDLE. key_start held continuously across IDLE entry does not restart; release then press restarts with lives=3.
- resetN low mid-DYING → state=IDLE, lives=3, level=1, kong_resetN=0 asynchronously, with no kong_sof pulses.
